lsu_mem_ctrl: RTL and testbench

Load/store controller between the execute stage and the data-memory `dual_ram` instance. It accepts one byte/half/word load or store per handshake and drives the RAM's `w_en`/`w_addr_i`/`w_data_i`/`r_en`/`r_addr_i` and consumes `r_data_o`. The RAM has no byte enables, so sub-word stores are performed as read-modify-write. Loaded data is returned lane-extracted and sign/zero-extended.

---
 rtl/lsu_mem_ctrl_pkg.sv | 23 ++
 rtl/lsu_byte_lane.sv | 42 ++++
 rtl/lsu_mem_ctrl.sv | 121 ++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the load/store controller: access size codes,
// FSM state encoding and the access legality check.
package lsu_mem_ctrl_pkg;

    localparam logic [1:0] LSU_SZ_B = 2'b00;
    localparam logic [1:0] LSU_SZ_H = 2'b01;
    localparam logic [1:0] LSU_SZ_W = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RMW  = 2'd2,
        ST_RESP = 2'd3
    } lsu_state_e;

    // Reserved size, odd half address, or word address not on a 4-byte boundary.
    function automatic logic access_err(input logic [1:0] size, input logic [1:0] lane);
        return (size == 2'b11) ||
               (size == LSU_SZ_H && lane[0]) ||
               (size == LSU_SZ_W && lane != 2'b00);
    endfunction

endpackage

// File: rtl/lsu_byte_lane.sv
// Little-endian lane logic: merges sub-word store data into an old word and
// extracts/extends sub-word load data from a RAM word.
module lsu_byte_lane
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] old_word,
    input  logic [DW-1:0] st_data,
    input  logic [1:0]    lane,
    input  logic [1:0]    size,
    input  logic          ld_unsigned,
    input  logic [DW-1:0] ld_word,
    output logic [DW-1:0] st_word,
    output logic [DW-1:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        st_word = old_word;
        case (size)
            LSU_SZ_B: st_word[{lane, 3'b000} +: 8]     = st_data[7:0];
            LSU_SZ_H: st_word[{lane[1], 4'b0000} +: 16] = st_data[15:0];
            LSU_SZ_W: st_word = st_data;
            default:  st_word = old_word;
        endcase
    end

    always_comb begin
        ld_byte = ld_word[{lane, 3'b000} +: 8];
        ld_half = ld_word[{lane[1], 4'b0000} +: 16];
        case (size)
            LSU_SZ_B: ld_data = {{(DW-8){~ld_unsigned & ld_byte[7]}}, ld_byte};
            LSU_SZ_H: ld_data = {{(DW-16){~ld_unsigned & ld_half[15]}}, ld_half};
            LSU_SZ_W: ld_data = ld_word;
            default:  ld_data = '0;
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller in front of a byte-enable-less dual-port RAM; sub-word
// stores are done as read-modify-write, loads are lane-extracted and extended.
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    output logic          req_ready_o,
    input  logic          req_we_i,
    input  logic [DW-1:0] req_addr_i,
    input  logic [1:0]    req_size_i,
    input  logic          req_unsigned_i,
    input  logic [DW-1:0] req_wdata_i,
    output logic          rsp_valid_o,
    output logic [DW-1:0] rsp_rdata_o,
    output logic          rsp_err_o,
    output logic          mem_w_en_o,
    output logic [AW-1:0] mem_w_addr_o,
    output logic [DW-1:0] mem_w_data_o,
    output logic          mem_r_en_o,
    output logic [AW-1:0] mem_r_addr_o,
    input  logic [DW-1:0] mem_r_data_i
);

    lsu_state_e    state, state_d;
    logic          accept;
    logic          req_err;
    logic [AW-1:0] req_word;
    logic [AW-1:0] addr_q;
    logic [1:0]    lane_q;
    logic [1:0]    size_q;
    logic          uns_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] merged;
    logic [DW-1:0] extracted;
    logic          unused_addr_hi;

    assign req_word       = req_addr_i[AW+1:2];
    assign unused_addr_hi = ^req_addr_i[DW-1:AW+2];
    assign req_ready_o    = rst && (state == ST_IDLE || state == ST_RESP);
    assign accept         = req_valid_i && req_ready_o;
    assign req_err        = access_err(req_size_i, req_addr_i[1:0]);

    // Both lane functions work on the latched request; RAM data arrives the cycle after accept.
    lsu_byte_lane #(.DW(DW)) u_lane (
        .old_word   (mem_r_data_i),
        .st_data    (wdata_q),
        .lane       (lane_q),
        .size       (size_q),
        .ld_unsigned(uns_q),
        .ld_word    (mem_r_data_i),
        .st_word    (merged),
        .ld_data    (extracted)
    );

    always_comb begin
        state_d      = state;
        mem_r_en_o   = 1'b0;
        mem_w_en_o   = 1'b0;
        mem_r_addr_o = req_word;
        mem_w_addr_o = req_word;
        mem_w_data_o = req_wdata_i;
        case (state)
            ST_IDLE, ST_RESP: begin
                state_d = ST_IDLE;
                if (accept) begin
                    if (req_err) begin
                        state_d = ST_RESP;
                    end else if (!req_we_i) begin
                        mem_r_en_o = 1'b1;
                        state_d    = ST_LOAD;
                    end else if (req_size_i == LSU_SZ_W) begin
                        mem_w_en_o = 1'b1;
                        state_d    = ST_RESP;
                    end else begin
                        mem_r_en_o = 1'b1;
                        state_d    = ST_RMW;
                    end
                end
            end
            ST_LOAD: state_d = ST_RESP;
            ST_RMW: begin
                mem_w_en_o   = 1'b1;
                mem_w_addr_o = addr_q;
                mem_w_data_o = merged;
                state_d      = ST_RESP;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_IDLE;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= '0;
        end else begin
            state       <= state_d;
            rsp_valid_o <= (state_d == ST_RESP);
            rsp_err_o   <= accept && req_err;
            rsp_rdata_o <= (state == ST_LOAD) ? extracted : '0;
        end
    end

    // Request fields are captured once on accept; later input changes are ignored.
    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q  <= req_word;
            lane_q  <= req_addr_i[1:0];
            size_q  <= req_size_i;
            uns_q   <= req_unsigned_i;
            wdata_q <= req_wdata_i;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Directed bench for lsu_mem_ctrl with a behavioural dual-port RAM that
// forwards same-cycle writes to the read port.
module tb_lsu_mem_ctrl;

    localparam int AW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_valid_i = 1'b0;
    logic          req_ready_o;
    logic          req_we_i = 1'b0;
    logic [31:0]   req_addr_i = '0;
    logic [1:0]    req_size_i = 2'b10;
    logic          req_unsigned_i = 1'b0;
    logic [31:0]   req_wdata_i = '0;
    logic          rsp_valid_o;
    logic [31:0]   rsp_rdata_o;
    logic          rsp_err_o;
    logic          mem_w_en_o;
    logic [AW-1:0] mem_w_addr_o;
    logic [31:0]   mem_w_data_o;
    logic          mem_r_en_o;
    logic [AW-1:0] mem_r_addr_o;
    logic [31:0]   ram_q;
    logic [31:0]   ram [0:(1<<AW)-1];

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(.DW(32), .AW(AW)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid_i),
        .req_ready_o   (req_ready_o),
        .req_we_i      (req_we_i),
        .req_addr_i    (req_addr_i),
        .req_size_i    (req_size_i),
        .req_unsigned_i(req_unsigned_i),
        .req_wdata_i   (req_wdata_i),
        .rsp_valid_o   (rsp_valid_o),
        .rsp_rdata_o   (rsp_rdata_o),
        .rsp_err_o     (rsp_err_o),
        .mem_w_en_o    (mem_w_en_o),
        .mem_w_addr_o  (mem_w_addr_o),
        .mem_w_data_o  (mem_w_data_o),
        .mem_r_en_o    (mem_r_en_o),
        .mem_r_addr_o  (mem_r_addr_o),
        .mem_r_data_i  (ram_q)
    );

    always @(posedge clk) begin
        if (mem_w_en_o) ram[mem_w_addr_o] <= mem_w_data_o;
        if (mem_r_en_o)
            ram_q <= (mem_w_en_o && mem_w_addr_o == mem_r_addr_o) ? mem_w_data_o : ram[mem_r_addr_o];
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int i);
        return 32'hC0DE_0000 ^ (32'(i) * 32'h0011_0011);
    endfunction

    task automatic single_req(input string tag, input logic we, input logic [31:0] addr,
                              input logic [1:0] size, input logic uns, input logic [31:0] wdata,
                              input logic exp_ren, input logic exp_wen, input logic exp_rmw,
                              input logic [31:0] exp_rmw_data, input int exp_lat,
                              input logic [31:0] exp_rdata, input logic exp_err);
        int lat;
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_addr_i     = addr;
        req_size_i     = size;
        req_unsigned_i = uns;
        req_wdata_i    = wdata;
        #1;
        check_vec({tag, ".ready"}, 32'(req_ready_o), 32'(1'b1));
        check_vec({tag, ".ren"}, 32'(mem_r_en_o), 32'(exp_ren));
        check_vec({tag, ".wen"}, 32'(mem_w_en_o), 32'(exp_wen));
        if (exp_ren) check_vec({tag, ".raddr"}, 32'(mem_r_addr_o), 32'(addr[AW+1:2]));
        if (exp_wen) begin
            check_vec({tag, ".waddr"}, 32'(mem_w_addr_o), 32'(addr[AW+1:2]));
            check_vec({tag, ".wdata"}, mem_w_data_o, wdata);
        end
        @(posedge clk);
        #1;
        req_valid_i    = 1'b0;
        req_addr_i     = 32'hFFFF_FFFF;
        req_size_i     = 2'b11;
        req_wdata_i    = 32'h0;
        req_unsigned_i = ~uns;
        #1;
        check_vec({tag, ".wen1"}, 32'(mem_w_en_o), 32'(exp_rmw));
        if (exp_rmw) begin
            check_vec({tag, ".rmw_addr"}, 32'(mem_w_addr_o), 32'(addr[AW+1:2]));
            check_vec({tag, ".rmw_data"}, mem_w_data_o, exp_rmw_data);
        end
        lat = 1;
        while (!rsp_valid_o && lat < 6) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_vec({tag, ".lat"}, 32'(lat), 32'(exp_lat));
        check_vec({tag, ".rdata"}, rsp_rdata_o, exp_rdata);
        check_vec({tag, ".err"}, 32'(rsp_err_o), 32'(exp_err));
        @(posedge clk);
        #1;
        check_vec({tag, ".pulse"}, 32'(rsp_valid_o), 32'(1'b0));
    endtask

    // Holds valid high and advances the address on every accept.
    task automatic burst(input string tag, input logic we, input logic [31:0] base,
                         input int n, input int exp_edges);
        int   acc_i;
        int   rsp_i;
        int   edges;
        logic acc;
        acc_i = 0;
        rsp_i = 0;
        edges = 0;
        @(negedge clk);
        req_valid_i    = 1'b1;
        req_we_i       = we;
        req_size_i     = 2'b10;
        req_unsigned_i = 1'b0;
        req_addr_i     = base;
        req_wdata_i    = pat(0);
        while (rsp_i < n && edges < 4 * n + 8) begin
            #1;
            acc = req_valid_i && req_ready_o;
            @(posedge clk);
            #1;
            edges++;
            if (rsp_valid_o) begin
                check_vec({tag, ".rdata"}, rsp_rdata_o, we ? 32'h0 : pat(rsp_i));
                rsp_i++;
            end
            if (acc) begin
                acc_i++;
                if (acc_i == n) begin
                    req_valid_i = 1'b0;
                end else begin
                    req_addr_i  = base + 32'(4 * acc_i);
                    req_wdata_i = pat(acc_i);
                end
            end
            @(negedge clk);
        end
        check_vec({tag, ".edges"}, 32'(edges), 32'(exp_edges));
        check_vec({tag, ".count"}, 32'(rsp_i), 32'(n));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < (1 << AW); i++) ram[i] = 32'h0;
        ram_q = 32'h0;

        req_valid_i = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check_vec("rst.ready", 32'(req_ready_o), 32'(1'b0));
        check_vec("rst.ren", 32'(mem_r_en_o), 32'(1'b0));
        check_vec("rst.wen", 32'(mem_w_en_o), 32'(1'b0));
        check_vec("rst.valid", 32'(rsp_valid_o), 32'(1'b0));
        check_vec("rst.err", 32'(rsp_err_o), 32'(1'b0));
        check_vec("rst.rdata", rsp_rdata_o, 32'h0);
        req_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("rst.ready_rel", 32'(req_ready_o), 32'(1'b1));

        //          tag      we    addr          sz     uns   wdata          ren   wen   rmw   rmw_data       lat rdata          err
        single_req("sw10",  1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0,         1, 32'h0,         1'b0);
        single_req("lw10",  1'b0, 32'h0000_0010, 2'b10, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'hDEAD_BEEF, 1'b0);
        check_vec("ram4", ram[4], 32'hDEAD_BEEF);
        single_req("sw10b", 1'b1, 32'h0000_0010, 2'b10, 1'b0, 32'h1122_3344, 1'b0, 1'b1, 1'b0, 32'h0,         1, 32'h0,         1'b0);
        single_req("sb13",  1'b1, 32'h0000_0013, 2'b00, 1'b0, 32'h0000_005A, 1'b1, 1'b0, 1'b1, 32'h5A22_3344, 2, 32'h0,         1'b0);
        single_req("lb13",  1'b0, 32'h0000_0013, 2'b00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h0000_005A, 1'b0);
        single_req("sb10",  1'b1, 32'h0000_0010, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b1, 1'b0, 1'b1, 32'h5A22_3380, 2, 32'h0,         1'b0);
        single_req("lb10s", 1'b0, 32'h0000_0010, 2'b00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'hFFFF_FF80, 1'b0);
        single_req("lb10u", 1'b0, 32'h0000_0010, 2'b00, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h0000_0080, 1'b0);
        single_req("lb12",  1'b0, 32'h0000_0012, 2'b00, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h0000_0022, 1'b0);
        single_req("lwhi",  1'b0, 32'h8000_0010, 2'b10, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h5A22_3380, 1'b0);
        single_req("sh22",  1'b1, 32'h0000_0022, 2'b01, 1'b0, 32'h0000_8001, 1'b1, 1'b0, 1'b1, 32'h8001_0000, 2, 32'h0,         1'b0);
        single_req("lh22s", 1'b0, 32'h0000_0022, 2'b01, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'hFFFF_8001, 1'b0);
        single_req("lh22u", 1'b0, 32'h0000_0022, 2'b01, 1'b1, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h0000_8001, 1'b0);
        single_req("lh20",  1'b0, 32'h0000_0020, 2'b01, 1'b0, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0,         2, 32'h0000_0000, 1'b0);
        single_req("elh01", 1'b0, 32'h0000_0001, 2'b01, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1, 32'h0,         1'b1);
        single_req("esw06", 1'b1, 32'h0000_0006, 2'b10, 1'b0, 32'hCAFE_F00D, 1'b0, 1'b0, 1'b0, 32'h0,         1, 32'h0,         1'b1);
        single_req("esz3",  1'b0, 32'h0000_0000, 2'b11, 1'b0, 32'h0,         1'b0, 1'b0, 1'b0, 32'h0,         1, 32'h0,         1'b1);
        check_vec("err.ram1", ram[1], 32'h0);

        burst("bsw", 1'b1, 32'h0000_0100, 8, 8);
        for (int i = 0; i < 8; i++) check_vec("bsw.ram", ram[64 + i], pat(i));
        burst("blw", 1'b0, 32'h0000_0100, 8, 16);

        single_req("sw24",  1'b1, 32'h0000_0024, 2'b10, 1'b0, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 32'h0,         1, 32'h0,         1'b0);
        @(negedge clk);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 32'h0000_0024;
        req_size_i  = 2'b00;
        req_wdata_i = 32'h0000_00FF;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        check_vec("abort.rmw_wen", 32'(mem_w_en_o), 32'(1'b1));
        #1;
        rst = 1'b0;
        #1;
        check_vec("abort.wen", 32'(mem_w_en_o), 32'(1'b0));
        check_vec("abort.ready", 32'(req_ready_o), 32'(1'b0));
        repeat (2) begin
            @(posedge clk);
            #1;
            check_vec("abort.valid", 32'(rsp_valid_o), 32'(1'b0));
        end
        check_vec("abort.ram9", ram[9], 32'h1234_5678);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_vec("abort.ready_rel", 32'(req_ready_o), 32'(1'b1));
        @(posedge clk);
        #1;
        check_vec("abort.valid_rel", 32'(rsp_valid_o), 32'(1'b0));
        check_vec("abort.wen_rel", 32'(mem_w_en_o), 32'(1'b0));
        check_vec("abort.ram9_rel", ram[9], 32'h1234_5678);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
